// File: rtl/button_event_scheduler.sv
// Debounces N_BTN raw buttons against a shared 1 ms tick and funnels their
// press/release edges through a round-robin arbiter onto one valid/ready port.

module btn_debounce_lane #(
  parameter int DEBOUNCE_MS = 5,
  parameter int CW          = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  input  logic tick,
  output logic state,
  output logic evt,
  output logic evt_type
);
  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          mism;

  assign mism     = sync[1] ^ state;
  assign evt      = tick & mism & (cnt == CW'(DEBOUNCE_MS - 1));
  assign evt_type = sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      cnt   <= '0;
      state <= 1'b0;
    end else begin
      sync <= {sync[0], btn};
      // Any agreeing cycle restarts the run, so short glitches never accumulate.
      if (!mism) begin
        cnt <= '0;
      end else if (tick) begin
        if (cnt == CW'(DEBOUNCE_MS - 1)) begin
          state <= sync[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule

module button_event_scheduler #(
  parameter int c_clkfreq   = 100000000,
  parameter int N_BTN       = 4,
  parameter int DEBOUNCE_MS = 5,
  localparam int IDW        = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_i,
  output logic [N_BTN-1:0] btn_state_o,
  output logic             evt_valid_o,
  input  logic             evt_ready_i,
  output logic [IDW-1:0]   evt_id_o,
  output logic             evt_type_o,
  output logic [N_BTN-1:0] ovr_o,
  input  logic             ovr_clr_i
);
  localparam int TICK_CYC = c_clkfreq / 1000;
  localparam int PW       = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int CW       = $clog2(DEBOUNCE_MS + 1);

  typedef struct packed {
    logic vld;
    logic typ;
  } slot_t;

  logic [PW-1:0]    pre_cnt;
  logic             tick;
  logic [N_BTN-1:0] lane_evt;
  logic [N_BTN-1:0] lane_typ;
  slot_t [N_BTN-1:0] slot;
  logic [IDW-1:0]   ptr;
  logic             load, gnt_any, grant;
  logic [IDW-1:0]   gnt_id;
  logic [N_BTN-1:0] slot_clr, ovr_set;

  assign tick = (pre_cnt == PW'(TICK_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + 1'b1;
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_lane
    btn_debounce_lane #(
      .DEBOUNCE_MS(DEBOUNCE_MS),
      .CW         (CW)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn     (btn_i[g]),
      .tick    (tick),
      .state   (btn_state_o[g]),
      .evt     (lane_evt[g]),
      .evt_type(lane_typ[g])
    );
  end

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    logic [IDW:0] sum;
    logic [IDW-1:0] idx;
    gnt_any = 1'b0;
    gnt_id  = '0;
    sum     = '0;
    idx     = '0;
    for (int k = 1; k <= N_BTN; k++) begin
      sum = {1'b0, ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(N_BTN)) sum = sum - (IDW+1)'(N_BTN);
      idx = sum[IDW-1:0];
      if (!gnt_any && slot[idx].vld) begin
        gnt_any = 1'b1;
        gnt_id  = idx;
      end
    end
  end

  assign load  = !evt_valid_o || evt_ready_i;
  assign grant = load && gnt_any;

  always_comb begin
    for (int c = 0; c < N_BTN; c++) slot_clr[c] = grant && (gnt_id == IDW'(c));
  end

  // A slot being granted this cycle can take a fresh event without overrun.
  always_comb begin
    for (int c = 0; c < N_BTN; c++) ovr_set[c] = lane_evt[c] && slot[c].vld && !slot_clr[c];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
    end else begin
      for (int c = 0; c < N_BTN; c++) begin
        if (lane_evt[c]) begin
          slot[c].vld <= 1'b1;
          slot[c].typ <= lane_typ[c];
        end else if (slot_clr[c]) begin
          slot[c].vld <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovr_o <= '0;
    else        ovr_o <= (ovr_clr_i ? '0 : ovr_o) | ovr_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid_o <= 1'b0;
      evt_id_o    <= '0;
      evt_type_o  <= 1'b0;
      ptr         <= IDW'(N_BTN - 1);
    end else if (load) begin
      if (gnt_any) begin
        evt_valid_o <= 1'b1;
        evt_id_o    <= gnt_id;
        evt_type_o  <= slot[gnt_id].typ;
        ptr         <= gnt_id;
      end else begin
        evt_valid_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_button_event_scheduler.sv
// Directed bench for button_event_scheduler: 10 cycles/tick, 3-tick debounce, 4 buttons.

module tb_button_event_scheduler;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn_i;
  logic [3:0] btn_state_o;
  logic       evt_valid_o;
  logic       evt_ready_i;
  logic [1:0] evt_id_o;
  logic       evt_type_o;
  logic [3:0] ovr_o;
  logic       ovr_clr_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  button_event_scheduler #(
    .c_clkfreq  (10000),
    .N_BTN      (4),
    .DEBOUNCE_MS(3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_i      (btn_i),
    .btn_state_o(btn_state_o),
    .evt_valid_o(evt_valid_o),
    .evt_ready_i(evt_ready_i),
    .evt_id_o   (evt_id_o),
    .evt_type_o (evt_type_o),
    .ovr_o      (ovr_o),
    .ovr_clr_i  (ovr_clr_i)
  );

  typedef struct {
    logic [3:0] btn;
    logic       rdy;
    int         cyc;
    logic [3:0] st;
    logic       vld;
    logic [1:0] id;
    logic       typ;
    logic [3:0] ovr;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_state(input int ch, input logic val, input int max_cyc, output int cyc);
    cyc = 0;
    while (btn_state_o[ch] !== val && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
    end
    if (btn_state_o[ch] !== val) begin
      checks++;
      errors++;
      $display("FAIL wait_state_ch%0d: got %0b expected %0b after %0d cycles", ch, btn_state_o[ch], val, cyc);
    end
  endtask

  task automatic wait_valid(input int max_cyc);
    int cyc = 0;
    while (evt_valid_o !== 1'b1 && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
    end
    if (evt_valid_o !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wait_valid: got %0b expected 1 after %0d cycles", evt_valid_o, cyc);
    end
  endtask

  task automatic reset_dut();
    btn_i       = '0;
    evt_ready_i = 1'b0;
    ovr_clr_i   = 1'b0;
    rst_n       = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int cyc;
    int rises, falls, nev, ev_ok, bad, early;
    logic prev;

    // ch0,1,3 pressed together (order 0,1,3), then ch2 moves the pointer, then ch0,3 released (order 3,0)
    tbl[0] = '{4'b1011, 1'b0, 40, 4'b1011, 1'b1, 2'd0, 1'b1, 4'b0000};
    tbl[1] = '{4'b1011, 1'b1,  1, 4'b1011, 1'b1, 2'd1, 1'b1, 4'b0000};
    tbl[2] = '{4'b1011, 1'b1,  1, 4'b1011, 1'b1, 2'd3, 1'b1, 4'b0000};
    tbl[3] = '{4'b1011, 1'b1,  1, 4'b1011, 1'b0, 2'd0, 1'b0, 4'b0000};
    tbl[4] = '{4'b1111, 1'b0, 40, 4'b1111, 1'b1, 2'd2, 1'b1, 4'b0000};
    tbl[5] = '{4'b1111, 1'b1,  1, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000};
    tbl[6] = '{4'b0110, 1'b0, 40, 4'b0110, 1'b1, 2'd3, 1'b0, 4'b0000};
    tbl[7] = '{4'b0110, 1'b1,  1, 4'b0110, 1'b1, 2'd0, 1'b0, 4'b0000};
    tbl[8] = '{4'b0110, 1'b1,  1, 4'b0110, 1'b0, 2'd0, 1'b0, 4'b0000};

    rst_n = 1'b0; btn_i = '0; evt_ready_i = 1'b0; ovr_clr_i = 1'b0;
    #1;
    chk("rst_state", 32'(btn_state_o), 0);
    chk("rst_valid", 32'(evt_valid_o), 0);
    chk("rst_id",    32'(evt_id_o), 0);
    chk("rst_type",  32'(evt_type_o), 0);
    chk("rst_ovr",   32'(ovr_o), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Clean press on ch1
    btn_i = 4'b0010;
    wait_state(1, 1'b1, 60, cyc);
    chk("press_latency_20_30", 32'((cyc - 2 >= 20) && (cyc - 2 <= 30)), 1);
    chk("press_valid_not_yet", 32'(evt_valid_o), 0);
    @(negedge clk);
    chk("press_valid", 32'(evt_valid_o), 1);
    chk("press_id",    32'(evt_id_o), 1);
    chk("press_type",  32'(evt_type_o), 1);
    evt_ready_i = 1'b1;
    @(negedge clk);
    chk("press_drop", 32'(evt_valid_o), 0);

    // Bounce on ch2: 15 high, 5 low, then held
    rises = 0; falls = 0; nev = 0; ev_ok = 1;
    prev = btn_state_o[2];
    for (int i = 0; i < 80; i++) begin
      btn_i[2] = (i < 15) ? 1'b1 : (i < 20) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (btn_state_o[2] && !prev) rises++;
      if (!btn_state_o[2] && prev) falls++;
      prev = btn_state_o[2];
      if (evt_valid_o) begin
        nev++;
        if (evt_id_o !== 2'd2 || evt_type_o !== 1'b1) ev_ok = 0;
      end
    end
    chk("bounce_rises",  32'(rises), 1);
    chk("bounce_falls",  32'(falls), 0);
    chk("bounce_events", 32'(nev), 1);
    chk("bounce_evt_ok", 32'(ev_ok), 1);
    chk("bounce_state",  32'(btn_state_o), 32'h6);

    // Backpressure on ch0
    evt_ready_i = 1'b0;
    btn_i = 4'b0111;
    wait_valid(60);
    chk("bp_id",   32'(evt_id_o), 0);
    chk("bp_type", 32'(evt_type_o), 1);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (evt_valid_o !== 1'b1 || evt_id_o !== 2'd0 || evt_type_o !== 1'b1) bad++;
    end
    chk("bp_hold_stable", 32'(bad), 0);
    evt_ready_i = 1'b1;
    @(negedge clk);
    chk("bp_accept", 32'(evt_valid_o), 0);
    evt_ready_i = 1'b0;

    // Overrun: output holds ch2 press while ch1 presses then releases
    reset_dut();
    btn_i = 4'b0100;
    wait_valid(60);
    chk("ovr_hold_id", 32'(evt_id_o), 2);
    btn_i = 4'b0110;
    wait_state(1, 1'b1, 40, cyc);
    chk("ovr_none_yet", 32'(ovr_o), 0);
    btn_i = 4'b0100;
    wait_state(1, 1'b0, 40, cyc);
    chk("ovr_bits",       32'(ovr_o), 32'h2);
    chk("ovr_still_held", 32'(evt_id_o), 2);
    evt_ready_i = 1'b1;
    @(negedge clk);
    evt_ready_i = 1'b0;
    chk("ovr_pend_valid", 32'(evt_valid_o), 1);
    chk("ovr_pend_id",    32'(evt_id_o), 1);
    chk("ovr_pend_type",  32'(evt_type_o), 0);
    ovr_clr_i = 1'b1;
    @(negedge clk);
    ovr_clr_i = 1'b0;
    chk("ovr_cleared", 32'(ovr_o), 0);
    btn_i = 4'b1100;
    wait_state(3, 1'b1, 40, cyc);
    chk("ovr_ch3_none", 32'(ovr_o), 0);
    ovr_clr_i = 1'b1;
    btn_i = 4'b0100;
    wait_state(3, 1'b0, 40, cyc);
    chk("ovr_set_wins", 32'(ovr_o), 32'h8);
    ovr_clr_i = 1'b0;
    @(negedge clk);
    chk("ovr_set_kept", 32'(ovr_o), 32'h8);
    evt_ready_i = 1'b1;
    @(negedge clk);
    chk("ovr_drain_id",   32'(evt_id_o), 3);
    chk("ovr_drain_type", 32'(evt_type_o), 0);
    @(negedge clk);
    chk("ovr_drain_done", 32'(evt_valid_o), 0);

    // Round-robin table
    reset_dut();
    for (int i = 0; i < 9; i++) begin
      btn_i       = tbl[i].btn;
      evt_ready_i = tbl[i].rdy;
      repeat (tbl[i].cyc) @(negedge clk);
      chk($sformatf("tbl%0d_state", i), 32'(btn_state_o), 32'(tbl[i].st));
      chk($sformatf("tbl%0d_valid", i), 32'(evt_valid_o), 32'(tbl[i].vld));
      if (tbl[i].vld) begin
        chk($sformatf("tbl%0d_id", i),   32'(evt_id_o),   32'(tbl[i].id));
        chk($sformatf("tbl%0d_type", i), 32'(evt_type_o), 32'(tbl[i].typ));
      end
      chk($sformatf("tbl%0d_ovr", i), 32'(ovr_o), 32'(tbl[i].ovr));
    end

    // Async reset while an event is held and ch3 is mid-debounce
    evt_ready_i = 1'b0;
    btn_i = 4'b0111;
    wait_valid(60);
    btn_i = 4'b1111;
    repeat (12) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(btn_state_o), 0);
    chk("arst_valid", 32'(evt_valid_o), 0);
    chk("arst_id",    32'(evt_id_o), 0);
    chk("arst_type",  32'(evt_type_o), 0);
    chk("arst_ovr",   32'(ovr_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    early = 0;
    repeat (20) begin
      @(negedge clk);
      if (evt_valid_o !== 1'b0 || btn_state_o !== 4'b0000) early++;
    end
    chk("arst_no_early_event", 32'(early), 0);
    repeat (20) @(negedge clk);
    chk("arst_redebounce_state", 32'(btn_state_o), 32'hF);
    chk("arst_redebounce_valid", 32'(evt_valid_o), 1);
    chk("arst_redebounce_id",    32'(evt_id_o), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/button_event_scheduler.md
Name: button_event_scheduler

Overview:
- Shares one 1 ms timebase across N_BTN raw button inputs and debounces them all.
- Detects press and release edges on each debounced level.
- A round-robin arbiter queues these events onto a single valid/ready event port.
- Sits between the board push-buttons and the control FSMs that consume button events.

Parameters:
- c_clkfreq, 100000000: clock frequency in Hz; clock cycles per 1 ms tick = c_clkfreq/1000.
- N_BTN, 4: number of button channels (1..16).
- DEBOUNCE_MS, 5: consecutive ms ticks of a stable new level needed to accept it (>=1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active-low.
- btn_i  in  N_BTN  raw asynchronous button levels, 1 = pressed.
- btn_state_o  out  N_BTN  debounced levels.
- evt_valid_o  out  1  event available.
- evt_ready_i  in  1  consumer accepts event.
- evt_id_o  out  clog2(N_BTN) (min 1)  channel index of the event.
- evt_type_o  out  1  1 = press (0->1), 0 = release (1->0).
- ovr_o  out  N_BTN  sticky per-channel overrun flags.
- ovr_clr_i  in  1  clears all ovr_o bits.

Behaviour:
- Reset (rst_n low, asynchronous) clears:
  - synchronisers, prescaler, per-channel counters, btn_state_o, pending slots, ovr_o, evt_valid_o/evt_id_o/evt_type_o;
  - round-robin pointer is set so channel 0 has highest priority first.
- Synchroniser: each btn_i bit passes through a 2-flop synchroniser (sync); no other logic uses btn_i directly.
- Prescaler:
  - free-running counter 0..c_clkfreq/1000-1;
  - tick is a one-cycle pulse on the cycle the counter wraps;
  - first tick occurs c_clkfreq/1000 cycles after reset release.
- Per-channel debounce, counter width clog2(DEBOUNCE_MS+1):
  - any cycle with sync == btn_state: counter <= 0;
  - on tick with sync != btn_state and counter < DEBOUNCE_MS-1: counter increments;
  - on tick with sync != btn_state and counter == DEBOUNCE_MS-1: btn_state <= sync, counter <= 0, generate an event of type = sync;
  - a glitch lasting shorter than one full mismatch run of DEBOUNCE_MS ticks produces no change;
  - acceptance latency after sync changes: (DEBOUNCE_MS-1) to DEBOUNCE_MS ms.
- Pending slots: one per channel, holding a valid bit and a type bit.
  - A new event writes the slot.
  - If the slot is already valid and not being granted this cycle: overwrite the type and set ovr_o[ch].
  - An event arriving in the same cycle the slot is granted: stored as new pending, no overrun.
- Arbiter / output register:
  - load condition: !evt_valid_o or evt_ready_i;
  - when the load condition holds and any slot is valid, select the first valid slot searching from pointer+1 round-robin;
  - the next edge registers evt_id_o/evt_type_o, sets evt_valid_o=1, clears that slot, and moves pointer to the granted id;
  - load condition true with no slot valid: evt_valid_o <= 0;
  - while evt_valid_o=1 and evt_ready_i=0: id and type are held stable;
  - back-to-back accepts allowed, one event per cycle;
  - minimum latency from btn_state update to evt_valid_o is 1 cycle.
- ovr_o: set as above.
  - ovr_clr_i clears all bits.
  - Set and clear in the same cycle: set wins.
- Reset mid-operation: pending and in-flight events are discarded; no event is emitted for the reset itself.

Test Plan:
- Bench config: c_clkfreq=10000 (10 cycles/tick), DEBOUNCE_MS=3, N_BTN=4.
- Clean press: btn_i[1] 0->1 and held.
  - Required: btn_state_o[1] rises 20-30 cycles after sync (3rd mismatched tick).
  - One event id=1 type=1; evt_ready_i=1 drops evt_valid_o after 1 cycle.
- Bounce rejection: btn_i[2] toggles 1 for 15 cycles, 0 for 5, then 1 held.
  - Required: exactly one press event id=2; btn_state_o[2] never glitches.
- Backpressure/hold: create press on ch0, keep evt_ready_i=0 for 100 cycles.
  - Required: evt_valid_o=1, id=0, type=1 stable throughout; accepted on the first ready cycle.
- Round-robin: ch0, ch1 and ch3 accepted on the same tick, evt_ready_i=1.
  - Required: events emitted on consecutive cycles in order id 0,1,3.
  - Next simultaneous batch on ch0 and ch3 is emitted 3 then 0.
- Overrun: hold evt_ready_i=0 with the output register holding ch2 press; ch1 press then release both accepted.
  - Required: ovr_o=4'b0010, pending ch1 type=0.
  - ovr_clr_i pulse clears ovr_o; an ovr_clr_i coinciding with a new overrun leaves the bit set.
- Async reset: assert rst_n low mid-debounce and while evt_valid_o=1.
  - Required: all outputs read 0 immediately, without a clock edge.
  - After release, no event is emitted until a new full debounce completes.
